alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that shares one 32-bit ALU datapath between `NUM_REQ` requesters. The ALU implements AND, OR, ADD, SUB and signed SLT with a zero flag, selected by a 3-bit function code `f`. Each requester issues operations over a valid/ready handshake. The block grants one request per cycle, computes the result, and holds it in a single output register with back-pressure. It sits between the instruction/sequencer front-ends and the shared ALU, and also keeps usage counters.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester index, equal to `$clog2(NUM_REQ)`.

Ports:
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req_valid` input, `NUM_REQ` bits: request i is presented.
- `req_ready` output, `NUM_REQ` bits: request i is accepted this cycle; at most one bit set.
- `req_a` input, `NUM_REQ*32` bits: operand a; slice i is `[32*i+31:32*i]`.
- `req_b` input, `NUM_REQ*32` bits: operand b, same slicing.
- `req_f` input, `NUM_REQ*3` bits: function code; slice i is `[3*i+2:3*i]`.
- `rsp_valid` output, 1 bit: output register holds a result.
- `rsp_ready` input, 1 bit: consumer takes the result.
- `rsp_id` output, `ID_W` bits: index of the requester that owns the result.
- `rsp_y` output, 32 bits: result.
- `rsp_z` output, 1 bit: 1 when `rsp_y == 0`.
- `op_count` output, 32 bits: number of accepted operations; wraps modulo 2^32.
- `stall_count` output, 32 bits: cycles in which `req_valid != 0` but no request was accepted; wraps.

## Operation
- **Function codes**
  - `f[2]` selects the b input: 1 uses `~b` with carry-in 1, 0 uses b with carry-in 0.
  - `f[1:0]` selects the result: 00 `a & b`, 01 `a | b`, 10 adder output, 11 signed `a < b` giving 1 or 0.
  - AND, OR and SLT ignore `f[2]`, so codes 100, 101 and 011 act as 000, 001 and 111.
  - Adder arithmetic is mod 2^32. No overflow or carry output.
- **Accept condition:** `can_accept = !rsp_valid || rsp_ready`.
- **Arbitration**
  - Round-robin pointer `ptr`, reset value 0.
  - The grant goes to the first i with `req_valid[i]` set, searching `ptr, ptr+1, …` modulo `NUM_REQ`.
  - `req_ready[i]` = granted(i) && `can_accept`. This is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
  - On acceptance of request g: `ptr <= (g+1) mod NUM_REQ`.
  - With no acceptance, `ptr` holds.
- **Output register**
  - On acceptance: `rsp_valid <= 1` and `rsp_id <= g`. `rsp_y` and `rsp_z` load the ALU result computed from request g's a, b and f.
  - Drain without a new acceptance (`rsp_valid && rsp_ready`): `rsp_valid <= 0`. `rsp_y`, `rsp_z` and `rsp_id` hold their last values.
  - Drain and accept in the same cycle: the new result loads and `rsp_valid` stays 1, giving back-to-back throughput of one operation per cycle.
  - While `rsp_valid && !rsp_ready`: all `rsp_*` outputs are stable and every `req_ready` bit is 0.
- **Counters**
  - `op_count` increments on each acceptance.
  - `stall_count` increments when `|req_valid && !(|req_ready)`.
- **Requester contract:** a requester keeps `req_valid` and its operands stable until it sees `req_ready`. The block does not check this.
- **States:** EMPTY (`rsp_valid` = 0) and FULL (`rsp_valid` = 1); transitions are given by the rules above.

## Timing
- **Reset (`rst_n` low, asynchronous):** `rsp_valid` = 0, `rsp_id` = 0, `rsp_y` = 0, `rsp_z` = 0, `ptr` = 0, `op_count` = 0, `stall_count` = 0. `req_ready` = 0 throughout reset.
- **Reset deassertion:** the first acceptance is possible on the first rising edge with `rst_n` high.
- **Reset mid-operation:** a pending result is discarded and nothing is replayed.
- **Latency:** a request accepted at edge k appears with `rsp_valid` = 1 after edge k, visible in cycle k+1.
- **Throughput:** 1 operation per cycle while `rsp_ready` = 1.
- **Fairness:** with all requesters continuously valid, each is granted exactly once in any `NUM_REQ` consecutive acceptances.

## Test plan
- **Reset values:** assert `rst_n` low mid-traffic → all outputs go to their reset values immediately (asynchronously) and `req_ready` = 0. After release, req0 ADD 5+7 → `rsp_y` = 12, `rsp_id` = 0.
- **Function sweep on requester 1**
  - a = 0xF0F0_0000, b = 0x0FF0_0000: f=000 → 0x00F0_0000; f=001 → 0xFFF0_0000.
  - f=010 with a = 0xFFFF_FFFF, b = 1 → 0, `rsp_z` = 1.
  - f=110 with a = 3, b = 5 → 0xFFFF_FFFE.
  - f=111 with a = 0xFFFF_FFFF, b = 1 → 1 (signed).
- **Round-robin:** all 4 requesters valid continuously, `rsp_ready` = 1 → `rsp_id` sequence 0,1,2,3,0,…; `op_count` = 8 after 8 cycles.
- **Back-pressure:** hold `rsp_ready` = 0 for 3 cycles with req2 valid → `rsp_y` and `rsp_id` stable, `req_ready` = 0, `stall_count` +3. On release → next result the following cycle.
- **Simultaneous drain and accept:** `rsp_valid` = 1, `rsp_ready` = 1, req3 valid → `rsp_valid` stays 1, new `rsp_id` = 3, no idle bubble.
- **Pointer wrap and hole skip:** only req0 and req3 valid, `ptr` = 1 → grant 3, then 0, then 3.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU (AND/OR/ADD/SUB/SLT) between NUM_REQ
// requesters, with a single back-pressured result register and usage counters.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_f,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_y,
    output logic                  rsp_z,
    output logic [31:0]           op_count,
    output logic [31:0]           stall_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_y;
    logic            r_z;
    logic [31:0]     r_op_count;
    logic [31:0]     r_stall_count;

    logic            w_found;
    logic [ID_W-1:0] w_gnt;
    logic [ID_W-1:0] w_ptr_next;
    logic            w_can_accept;
    logic            w_accept;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [31:0]     w_bx;
    logic [31:0]     w_sum;
    logic [31:0]     w_y;
    logic [2:0]      w_f;

    // Search starts at the round-robin pointer and wraps around the requester ring.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_can_accept = (r_state == EMPTY) || rsp_ready;
    // rst_n gates the handshake so nothing looks accepted while reset is held.
    assign w_accept     = rst_n && w_found && w_can_accept;
    assign w_ptr_next   = (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_a   = req_a[32*int'(w_gnt) +: 32];
    assign w_b   = req_b[32*int'(w_gnt) +: 32];
    assign w_f   = req_f[3*int'(w_gnt) +: 3];
    assign w_bx  = w_f[2] ? ~w_b : w_b;
    assign w_sum = w_a + w_bx + {31'd0, w_f[2]};

    always_comb begin
        case (w_f[1:0])
            2'b00:   w_y = w_a & w_b;
            2'b01:   w_y = w_a | w_b;
            2'b10:   w_y = w_sum;
            default: w_y = {31'd0, $signed(w_a) < $signed(w_b)};
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = FULL;
        end else if ((r_state == FULL) && rsp_ready) begin
            w_state_next = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_id          <= '0;
            r_y           <= '0;
            r_z           <= 1'b0;
            r_op_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept) begin
                r_ptr      <= w_ptr_next;
                r_id       <= w_gnt;
                r_y        <= w_y;
                r_z        <= (w_y == 32'd0);
                r_op_count <= r_op_count + 32'd1;
            end
            if ((|req_valid) && !w_accept) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign rsp_valid   = (r_state == FULL);
    assign rsp_id      = r_id;
    assign rsp_y       = r_y;
    assign rsp_z       = r_z;
    assign op_count    = r_op_count;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of arbitration, ALU and counters.
module tb_alu_share_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*3-1:0]  req_f;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_y;
    logic            rsp_z;
    logic [31:0]     op_count;
    logic [31:0]     stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr;
    int            m_g;
    logic          m_valid;
    logic [IW-1:0] m_id;
    logic [31:0]   m_y;
    logic          m_z;
    logic [31:0]   m_ops;
    logic [31:0]   m_stalls;
    logic [N-1:0]  m_ready;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_f       (req_f),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_y       (rsp_y),
        .rsp_z       (rsp_z),
        .op_count    (op_count),
        .stall_count (stall_count)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        case (f[1:0])
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return f[2] ? (a - b) : (a + b);
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic void model_reset();
        m_ptr    = 0;
        m_valid  = 1'b0;
        m_id     = '0;
        m_y      = '0;
        m_z      = 1'b0;
        m_ops    = '0;
        m_stalls = '0;
        m_ready  = '0;
    endfunction

    function automatic void predict();
        logic can;
        can     = !m_valid || rsp_ready;
        m_g     = -1;
        m_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        end
        if (m_g >= 0 && can && rst_n) m_ready[m_g] = 1'b1;
    endfunction

    // Advances one clock edge and updates the model with what that edge should do.
    task automatic tick();
        predict();
        @(posedge clk);
        if (m_ready != '0) begin
            m_valid = 1'b1;
            m_id    = IW'(m_g);
            m_y     = alu_ref(req_a[32*m_g +: 32], req_b[32*m_g +: 32], req_f[3*m_g +: 3]);
            m_z     = (m_y == 32'd0);
            m_ptr   = (m_g + 1) % N;
            m_ops   = m_ops + 32'd1;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        if ((|req_valid) && (m_ready == '0)) m_stalls = m_stalls + 32'd1;
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f);
        req_valid[i]       = 1'b1;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_f[3*i +: 3]    = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_f = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_z, op_count, stall_count} !== '0) begin
            errors++; $display("FAIL reset_outputs: valid=%b id=%0d y=%h z=%b ops=%0d stalls=%0d expected all 0",
                               rsp_valid, rsp_id, rsp_y, rsp_z, op_count, stall_count);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
        set_req(0, 32'd1, 32'd2, 3'b010);
        tick();
        req_valid = '0;
        set_req(1, 32'd9, 32'd9, 3'b000);
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'd3 || stall_count !== 32'd1) begin
            errors++; $display("FAIL pre_reset_traffic: valid=%b y=%0d stalls=%0d expected 1 3 1",
                               rsp_valid, rsp_y, stall_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({rsp_valid, rsp_id, rsp_y, rsp_z, op_count, stall_count} !== '0 || req_ready !== 4'h0) begin
            errors++; $display("FAIL async_reset: valid=%b id=%0d y=%h ops=%0d stalls=%0d ready=%b expected all 0",
                               rsp_valid, rsp_id, rsp_y, op_count, stall_count, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (op_count !== 32'd0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL held_reset: ops=%0d valid=%b expected 0 0", op_count, rsp_valid);
        end
        rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL no_replay: valid=%b expected 0", rsp_valid);
        end
        set_req(0, 32'd5, 32'd7, 3'b010);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL post_reset_ready: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'd12 || rsp_id !== 2'd0 || op_count !== 32'd1) begin
            errors++; $display("FAIL post_reset_add: valid=%b y=%0d id=%0d ops=%0d expected 1 12 0 1",
                               rsp_valid, rsp_y, rsp_id, op_count);
        end
        tick();
    endtask

    task automatic test_functions();
        logic [31:0] ta [8] = '{32'hF0F0_0000, 32'hF0F0_0000, 32'hFFFF_FFFF, 32'd3,
                                32'hFFFF_FFFF, 32'hF0F0_0000, 32'hF0F0_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [8] = '{32'h0FF0_0000, 32'h0FF0_0000, 32'd1, 32'd5,
                                32'd1, 32'h0FF0_0000, 32'h0FF0_0000, 32'd1};
        logic [2:0]  tf [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101, 3'b011};
        logic [31:0] ty [8] = '{32'h00F0_0000, 32'hFFF0_0000, 32'd0, 32'hFFFF_FFFE,
                                32'd1, 32'h00F0_0000, 32'hFFF0_0000, 32'd1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = '0;
            set_req(1, ta[i], tb[i], tf[i]);
            #1;
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++; $display("FAIL func_ready[%0d]: got %b expected 0010", i, req_ready);
            end
            tick();
            req_valid = '0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== ty[i] || rsp_z !== (ty[i] == 32'd0)) begin
                errors++; $display("FAIL func[%0d] f=%b: valid=%b id=%0d y=%h z=%b expected 1 1 %h %b",
                                   i, tf[i], rsp_valid, rsp_id, rsp_y, rsp_z, ty[i], ty[i] == 32'd0);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 16 + 1), 32'(i), 3'b010);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IW'(k % N) || rsp_y !== 32'((k % N) * 17 + 1)) begin
                errors++; $display("FAIL rr[%0d]: valid=%b id=%0d y=%0d expected 1 %0d %0d",
                                   k, rsp_valid, rsp_id, rsp_y, k % N, (k % N) * 17 + 1);
            end
        end
        checks++;
        if (op_count !== 32'd8 || stall_count !== 32'd0) begin
            errors++; $display("FAIL rr_counts: ops=%0d stalls=%0d expected 8 0", op_count, stall_count);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [31:0] st0;
        rsp_ready = 1'b1;
        req_valid = '0;
        set_req(2, 32'h1234, 32'h0101, 3'b010);
        tick();
        req_valid = '0;
        set_req(2, 32'd100, 32'd1, 3'b110);
        rsp_ready = 1'b0;
        st0 = stall_count;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 32'h1335) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b id=%0d y=%h expected 1 2 1335",
                                   c, rsp_valid, rsp_id, rsp_y);
            end
        end
        checks++;
        if (stall_count !== st0 + 32'd3) begin
            errors++; $display("FAIL bp_stalls: got %0d expected %0d", stall_count, st0 + 32'd3);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 32'd99) begin
            errors++; $display("FAIL bp_release: valid=%b id=%0d y=%0d expected 1 2 99", rsp_valid, rsp_id, rsp_y);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        set_req(3, 32'd7, 32'd9, 3'b111);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL b2b_ready: valid=%b ready=%b expected 1 1000", rsp_valid, req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 32'd1) begin
            errors++; $display("FAIL b2b: valid=%b id=%0d y=%0d expected 1 3 1", rsp_valid, rsp_id, rsp_y);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd3 || rsp_y !== 32'd1 || rsp_z !== 1'b0) begin
            errors++; $display("FAIL drain_hold: valid=%b id=%0d y=%0d z=%b expected 0 3 1 0",
                               rsp_valid, rsp_id, rsp_y, rsp_z);
        end
    endtask

    task automatic test_wrap_skip();
        logic [1:0]  exp_id [3] = '{2'd3, 2'd0, 2'd3};
        logic [31:0] exp_y  [3] = '{32'd21, 32'd11, 32'd21};
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_reset();
        rsp_ready = 1'b1;
        req_valid = '0;
        set_req(0, 32'd1, 32'd1, 3'b010);
        tick();
        req_valid = '0;
        set_req(0, 32'd10, 32'd1, 3'b010);
        set_req(3, 32'd20, 32'd1, 3'b010);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rsp_id !== exp_id[k] || rsp_y !== exp_y[k]) begin
                errors++; $display("FAIL wrap[%0d]: id=%0d y=%0d expected %0d %0d",
                                   k, rsp_id, rsp_y, exp_id[k], exp_y[k]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom();
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom();
                    set_req(i, a, b, 3'($urandom_range(0, 7)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            predict();
            checks++;
            if (req_ready !== m_ready) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, m_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_y !== m_y || rsp_z !== m_z) begin
                errors++; $display("FAIL rnd_rsp[%0d]: valid=%b id=%0d y=%h z=%b expected %b %0d %h %b",
                                   c, rsp_valid, rsp_id, rsp_y, rsp_z, m_valid, m_id, m_y, m_z);
            end
            checks++;
            if (op_count !== m_ops || stall_count !== m_stalls) begin
                errors++; $display("FAIL rnd_cnt[%0d]: ops=%0d stalls=%0d expected %0d %0d",
                                   c, op_count, stall_count, m_ops, m_stalls);
            end
            for (int i = 0; i < N; i++) if (m_ready[i]) req_valid[i] = 1'b0;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_functions();
        test_round_robin();
        test_back_pressure();
        test_back_to_back();
        test_wrap_skip();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit reached");
    end

endmodule
